clk_switch_ctrl: RTL

//  Sequencer driving the select of a glitch-free 2-input clock mux. Accepts switch requests via

---
 rtl/clksw_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/clk_switch_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/clksw_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : clksw_pkg                                                       |
// | Brief   : Shared state encoding and clock-source constants for the        |
// |           clock switch controller.                                        |
// | Revision: 1.0 - initial release                                           |
// +---------------------------------------------------------------------------+
package clksw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2
  } clksw_state_t;

  localparam logic SEL_CLK1 = 1'b0;
  localparam logic SEL_CLK2 = 1'b1;

  function automatic logic sel_other(input logic sel);
    return (sel == SEL_CLK1) ? SEL_CLK2 : SEL_CLK1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : sync_2ff                                                        |
// | Brief   : STAGES-deep flop synchronizer with async active-high reset.     |
// | Revision: 1.0 - initial release                                           |
// +---------------------------------------------------------------------------+
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module  : clk_switch_ctrl                                                 |
// | Brief   : Glitch-free clock mux select sequencer; confirms a switch by    |
// |           counting muxed-clock edges. CLK_SWITCH_REVERT_EN: on timeout    |
// |           the select reverts to the last confirmed source.                |
// | Revision: 1.0 - initial release                                           |
// +---------------------------------------------------------------------------+
module clk_switch_ctrl
  import clksw_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   SETTLE_CYC  = 8,
  parameter int   MIN_EDGES   = 4,
  parameter int   TIMEOUT_CYC = 256,
  parameter logic RESET_SEL   = SEL_CLK1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic clk_mon,
  output logic mux_sel,
  output logic cur_sel,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int c_settle_w = $clog2(SETTLE_CYC + 1);
  localparam int c_edge_w   = $clog2(MIN_EDGES + 1);
  localparam int c_timer_w  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYC - 1);
  localparam logic [c_settle_w-1:0] c_settle_max  = c_settle_w'(SETTLE_CYC);
  localparam logic [c_settle_w-1:0] c_settle_one  = c_settle_w'(1);
  localparam logic [c_edge_w-1:0]   c_edge_max    = c_edge_w'(MIN_EDGES);
  localparam logic [c_edge_w-1:0]   c_edge_one    = c_edge_w'(1);
  localparam logic [c_timer_w-1:0]  c_timer_max   = c_timer_w'(TIMEOUT_CYC);
  localparam logic [c_timer_w-1:0]  c_timer_one   = c_timer_w'(1);

  clksw_state_t          r_state;
  logic                  r_mux_sel;
  logic                  r_cur_sel;
  logic                  r_busy;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_err;
  logic [c_settle_w-1:0] r_settle_cnt;
  logic [c_edge_w-1:0]   r_edge_cnt;
  logic [c_timer_w-1:0]  r_timer;
  logic                  r_edge_q;

  logic                  w_sync_q;
  logic                  w_rise;
  logic [c_settle_w-1:0] w_settle_nxt;
  logic [c_edge_w-1:0]   w_edge_nxt;
  logic [c_timer_w-1:0]  w_timer_nxt;

  sync_2ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (clk_mon),
    .q   (w_sync_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_q <= 1'b0;
    end else begin
      r_edge_q <= w_sync_q;
    end
  end

  assign w_rise = w_sync_q & ~r_edge_q;

  // All counters hold at their terminal value instead of wrapping.
  assign w_settle_nxt = (r_settle_cnt == c_settle_max) ? r_settle_cnt : r_settle_cnt + c_settle_one;
  assign w_edge_nxt   = (!w_rise || (r_edge_cnt == c_edge_max)) ? r_edge_cnt : r_edge_cnt + c_edge_one;
  assign w_timer_nxt  = (r_timer == c_timer_max) ? r_timer : r_timer + c_timer_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mux_sel    <= RESET_SEL;
      r_cur_sel    <= RESET_SEL;
      r_busy       <= 1'b0;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_settle_cnt <= '0;
      r_edge_cnt   <= '0;
      r_timer      <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid && r_ready) begin
            if (req_sel == r_cur_sel) begin
              r_done <= 1'b1;
            end else begin
              r_mux_sel    <= req_sel;
              r_settle_cnt <= '0;
              r_state      <= SETTLE;
              r_busy       <= 1'b1;
              r_ready      <= 1'b0;
            end
          end
        end
        SETTLE: begin
          r_settle_cnt <= w_settle_nxt;
          if (r_settle_cnt == c_settle_last) begin
            r_state    <= COUNT;
            r_edge_cnt <= '0;
            r_timer    <= '0;
          end
        end
        COUNT: begin
          r_edge_cnt <= w_edge_nxt;
          r_timer    <= w_timer_nxt;
          // Edge success is checked first so it wins a same-cycle timeout.
          if (w_edge_nxt == c_edge_max) begin
            r_cur_sel <= r_mux_sel;
            r_done    <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
          end else if (w_timer_nxt == c_timer_max) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
`ifdef CLK_SWITCH_REVERT_EN
            r_mux_sel <= r_cur_sel;
`else
            r_mux_sel <= r_mux_sel;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign mux_sel   = r_mux_sel;
  assign cur_sel   = r_cur_sel;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire
